// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit processor: default widths, reset PC,
// fetch queue depth and the fetch-queue entry layout.
package cpu_pkg;

    localparam int DEFAULT_ADDR_W  = 8;
    localparam int DEFAULT_INSTR_W = 16;
    localparam logic [DEFAULT_ADDR_W-1:0] DEFAULT_RESET_PC = 8'h00;
    localparam int IF_QUEUE_DEPTH  = 2;

    // One buffered fetch: the instruction and the address it came from.
    typedef struct packed {
        logic [DEFAULT_INSTR_W-1:0] instr;
        logic [DEFAULT_ADDR_W-1:0]  pc;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO of fetch entries. Flush empties the queue and
// takes priority over push and pop in the same cycle. The head reads as zero
// while the queue is empty.
module fetch_queue
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    input  logic               flush,
    output logic [1:0]         count,
    output logic [ENTRY_W-1:0] head
);

    logic [ENTRY_W-1:0] mem [IF_QUEUE_DEPTH];
    logic               rd_ptr;
    logic               wr_ptr;
    logic               do_push;
    logic               do_pop;

    // A pop frees a slot in the same cycle, so a full queue can push while popping.
    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    // Pointer and occupancy tracking; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset; count decides what is meaningful.
    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = (count != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues synchronous imem reads from the current PC,
// buffers returned instructions in a 2-entry queue for decode, and computes
// the next PC (reset, redirect, increment or hold) for an un-enabled PC register.
//
// Decode handshake: id_valid/id_instr/id_pc describe the queue head; a
// transfer completes on a rising edge where id_valid and id_ready are both 1.
// While id_valid is 1 and id_ready is 0 the head holds stable.
module if_stage
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = DEFAULT_ADDR_W,
    parameter int                INSTR_W  = DEFAULT_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pcnext,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc
);

    logic [1:0]        count;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;
    logic              kill;
    logic              pop;
    logic              push;
    logic              flush;
    logic [2:0]        occupancy;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    assign pop   = id_valid && id_ready;
    assign flush = redirect_valid && !rst;

    // Slots that will be claimed after this edge: entries left after the pop
    // plus the response still on its way. Issue only if one slot stays free,
    // so every response has room and the queue never overflows.
    assign occupancy = {1'b0, count} - {2'b00, pop} + {2'b00, inflight};
    assign imem_en   = !rst && !redirect_valid && (occupancy <= 3'd1);
    assign imem_addr = pc;

    // A response is kept unless it belongs to a fetch overtaken by a redirect.
    assign push             = inflight && !kill;
    assign push_entry.instr = imem_rdata;
    assign push_entry.pc    = inflight_pc;

    // Next PC for the PC register, which loads unconditionally every cycle.
    always_comb begin
        pcnext = pc;
        if (rst) begin
            pcnext = RESET_PC;
        end else if (redirect_valid) begin
            pcnext = redirect_target;
        end else if (imem_en) begin
            pcnext = pc + ADDR_W'(1);
        end
    end

    // Track the outstanding fetch and whether its response must be discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            kill     <= 1'b0;
        end else begin
            inflight <= imem_en;
            kill     <= redirect_valid;
        end
    end

    // Remember which address the outstanding fetch was issued for.
    always_ff @(posedge clk) begin
        if (imem_en) begin
            inflight_pc <= pc;
        end
    end

    fetch_queue u_fetch_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (flush),
        .count     (count),
        .head      (head_entry)
    );

    assign id_valid = (count != 2'd0);
    assign id_instr = head_entry.instr;
    assign id_pc    = head_entry.pc;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: an un-enabled PC register and a synchronous imem
// (imem[a] = 16'hA000 + a) surround the DUT. A stream model predicts the
// address sequence decode must see: it restarts at RESET_PC on reset and at
// the target on a redirect, and otherwise advances by one per transfer.
`timescale 1ns/1ps
module tb_if_stage;
    import cpu_pkg::*;

    localparam int AW = 8;
    localparam int IW = 16;
    localparam logic [AW-1:0] RPC = 8'h00;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc;
    logic [AW-1:0] pcnext;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_target;
    logic          id_valid;
    logic          id_ready;
    logic [IW-1:0] id_instr;
    logic [AW-1:0] id_pc;

    int vectors     = 0;
    int miscompares = 0;

    logic [AW-1:0] exp_q[$];
    int            gap = 0;
    logic          hold_pending = 1'b0;
    logic [AW-1:0] held_pc;
    logic [IW-1:0] held_instr;

    if_stage dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .pcnext          (pcnext),
        .imem_en         (imem_en),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_instr        (id_instr),
        .id_pc           (id_pc)
    );

    // Clock and global time limit.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000ns");
        $fatal(1, "time limit");
    end

    // Environment: PC register with no enable or reset, and synchronous imem.
    always @(posedge clk) pc <= pcnext;
    always @(posedge clk) if (imem_en) imem_rdata <= 16'hA000 + {8'h00, imem_addr};

    function automatic logic [IW-1:0] imem_word(input logic [AW-1:0] a);
        return 16'hA000 + {8'h00, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver: apply inputs for a cycle, then move to the sampling point.
    task automatic drive(input logic r, input logic rdy, input logic rv, input logic [AW-1:0] tgt);
        rst             = r;
        id_ready        = rdy;
        redirect_valid  = rv;
        redirect_target = tgt;
        @(negedge clk);
    endtask

    // Per-cycle rules plus the stream scoreboard, evaluated at the negedge.
    task automatic monitor();
        logic [AW-1:0] exp_next;
        logic [AW-1:0] head;
        if (!$isunknown(pc)) begin
            check("imem_addr", imem_addr, pc);
        end
        if (rst)                 exp_next = RPC;
        else if (redirect_valid) exp_next = redirect_target;
        else if (imem_en)        exp_next = 8'(pc + 8'd1);
        else                     exp_next = pc;
        check("pcnext", pcnext, exp_next);
        if (rst || redirect_valid) begin
            check("no_issue", imem_en, 1'b0);
        end
        if (hold_pending) begin
            check("hold_pc", id_pc, held_pc);
            check("hold_instr", id_instr, held_instr);
        end
        hold_pending = !rst && !redirect_valid && id_valid && !id_ready;
        held_pc      = id_pc;
        held_instr   = id_instr;
        if (rst) begin
            exp_q.delete();
            exp_q.push_back(RPC);
            gap = 0;
        end else begin
            if (id_valid && id_ready) begin
                check("sb_depth", exp_q.size(), 1);
                head = exp_q.pop_front();
                check("id_pc", id_pc, head);
                check("id_instr", id_instr, imem_word(head));
                exp_q.push_back(8'(head + 8'd1));
            end
            if (redirect_valid) begin
                exp_q.delete();
                exp_q.push_back(redirect_target);
            end
            if (redirect_valid || id_valid) gap = 0;
            else                            gap++;
            check("fill_gap", gap <= 2, 1'b1);
        end
    endtask

    task automatic step_done();
        monitor();
        @(posedge clk);
        #1;
    endtask

    // First cycles after reset release: latency, first instruction, no gaps.
    task automatic restart_checks();
        drive(0, 1, 0, 8'h00);
        check("R_pc", pc, RPC);
        check("R_imem_en", imem_en, 1'b1);
        check("R_imem_addr", imem_addr, RPC);
        check("R_pcnext", pcnext, 8'(RPC + 8'd1));
        check("R_id_valid", id_valid, 1'b0);
        step_done();
        drive(0, 1, 0, 8'h00);
        check("R1_id_valid", id_valid, 1'b0);
        step_done();
        drive(0, 1, 0, 8'h00);
        check("R2_id_valid", id_valid, 1'b1);
        check("R2_id_pc", id_pc, RPC);
        check("R2_id_instr", id_instr, 16'hA000);
        step_done();
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 0, 8'h00);
            check("stream_valid", id_valid, 1'b1);
            step_done();
        end
    endtask

    // Redirect in cycle t, target fetched in t+1, visible on id_* in t+3.
    task automatic redirect_case(input logic [AW-1:0] tgt, input logic rdy, input string tag);
        drive(0, rdy, 1, tgt);
        check({tag, "_en"}, imem_en, 1'b0);
        check({tag, "_pcnext"}, pcnext, tgt);
        step_done();
        drive(0, 1, 0, 8'h00);
        check({tag, "_pc"}, pc, tgt);
        check({tag, "_t1_en"}, imem_en, 1'b1);
        check({tag, "_t1_valid"}, id_valid, 1'b0);
        step_done();
        drive(0, 1, 0, 8'h00);
        check({tag, "_t2_valid"}, id_valid, 1'b0);
        step_done();
        drive(0, 1, 0, 8'h00);
        check({tag, "_t3_valid"}, id_valid, 1'b1);
        check({tag, "_t3_pc"}, id_pc, tgt);
        check({tag, "_t3_instr"}, id_instr, imem_word(tgt));
        step_done();
    endtask

    task automatic free_run(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 1, 0, 8'h00);
            step_done();
        end
    endtask

    initial begin
        logic [AW-1:0] frozen_pc;
        rst             = 1'b1;
        id_ready        = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 8'h00;
        @(posedge clk);
        #1;

        // Reset, with a redirect request that must be ignored.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, (i == 1), 8'h55);
            check("rst_id_valid", id_valid, 1'b0);
            check("rst_pcnext", pcnext, RPC);
            step_done();
        end
        restart_checks();

        // Backpressure: queue saturates, issue stops, PC freezes.
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 8'h00);
            check("bp_id_valid", id_valid, 1'b1);
            if (i >= 1) begin
                check("bp_imem_en", imem_en, 1'b0);
                check("bp_pc_hold", pcnext, pc);
            end
            if (i == 1) frozen_pc = pc;
            if (i == 5) check("bp_pc_frozen", pc, frozen_pc);
            step_done();
        end
        free_run(4);

        // Redirect with a full queue.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 8'h00);
            step_done();
        end
        redirect_case(8'h40, 1'b0, "redir_full");
        free_run(3);

        // Redirect coinciding with a pop, then with id_ready low.
        redirect_case(8'h10, 1'b1, "redir_pop");
        free_run(3);
        redirect_case(8'h10, 1'b0, "redir_stall");
        free_run(5);

        // Address wrap.
        redirect_case(8'hFE, 1'b1, "wrap");
        for (int k = 1; k <= 3; k++) begin
            drive(0, 1, 0, 8'h00);
            check("wrap_seq", id_pc, 8'(8'hFE + k));
            step_done();
        end

        // Reset mid-stream with a fetch in flight.
        drive(1, 1, 0, 8'h00);
        check("mid_rst_pcnext", pcnext, RPC);
        step_done();
        drive(1, 1, 1, 8'h77);
        check("mid_rst_id_valid", id_valid, 1'b0);
        check("mid_rst_pcnext2", pcnext, RPC);
        step_done();
        drive(1, 0, 0, 8'h00);
        check("mid_rst_id_valid2", id_valid, 1'b0);
        step_done();
        restart_checks();

        // Random traffic: backpressure, redirects and rare resets.
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 15) == 0),
                  8'($urandom_range(0, 255)));
            step_done();
        end
        free_run(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
